// File: rtl/bridge_1x2.sv
// bridge_1x2
//   Steers one SRAM-like master onto one of two SRAM-like slaves by address
//   decode: slave 0 is the data RAM, slave 1 the config/peripheral window
//   ((m_addr & CONF_MASK) == CONF_BASE). Both directions are purely
//   combinational. The control state is one outstanding counter, the slave
//   those requests went to, and a sticky error flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m_req/m_wr/m_size/m_addr/m_wdata   master request side (inputs)
//   m_addr_ok, m_data_ok, m_rdata       master handshake / response (outputs)
//   sN_req                   request to slave N (only the decoded slave)
//   sN_wr/size/addr/wdata    unconditional passthrough of the master fields
//   sN_addr_ok, sN_data_ok, sN_rdata    slave N handshake / response (inputs)
//   err                      sticky: a slave data_ok arrived unexpectedly
module bridge_1x2 #(
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000,
  parameter int          MAX_OUT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_req,
  input  logic        m_wr,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_addr_ok,
  output logic        m_data_ok,
  output logic [31:0] m_rdata,
  output logic        s0_req,
  output logic        s0_wr,
  output logic [1:0]  s0_size,
  output logic [31:0] s0_addr,
  output logic [31:0] s0_wdata,
  input  logic        s0_addr_ok,
  input  logic        s0_data_ok,
  input  logic [31:0] s0_rdata,
  output logic        s1_req,
  output logic        s1_wr,
  output logic [1:0]  s1_size,
  output logic [31:0] s1_addr,
  output logic [31:0] s1_wdata,
  input  logic        s1_addr_ok,
  input  logic        s1_data_ok,
  input  logic [31:0] s1_rdata,
  output logic        err
);

  localparam int            CW   = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          tgt;

  logic sel;
  logic busy;
  logic stall;
  logic issue;
  logic sel_addr_ok;
  logic tgt_data_ok;
  logic unexp;

  assign sel  = ((m_addr & CONF_MASK) == CONF_BASE);
  assign busy = (cnt != '0);

  // Holding every outstanding request on a single slave is what keeps
  // responses in order without any reorder buffer.
  assign stall = (cnt == FULL) | (busy & (sel != tgt));
  assign issue = m_req & ~stall;

  assign s0_req = issue & ~sel;
  assign s1_req = issue & sel;

  assign s0_wr    = m_wr;
  assign s0_size  = m_size;
  assign s0_addr  = m_addr;
  assign s0_wdata = m_wdata;
  assign s1_wr    = m_wr;
  assign s1_size  = m_size;
  assign s1_addr  = m_addr;
  assign s1_wdata = m_wdata;

  assign sel_addr_ok = sel ? s1_addr_ok : s0_addr_ok;
  assign m_addr_ok   = issue & sel_addr_ok;

  assign tgt_data_ok = tgt ? s1_data_ok : s0_data_ok;
  assign m_data_ok   = busy & tgt_data_ok;
  assign m_rdata     = busy ? (tgt ? s1_rdata : s0_rdata) : 32'h0;

  // With nothing outstanding tgt is meaningless, so any response is stray;
  // otherwise only the non-target slave can produce a stray response.
  assign unexp = busy ? (tgt ? s0_data_ok : s1_data_ok)
                      : (s0_data_ok | s1_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tgt <= 1'b0;
      err <= 1'b0;
    end else begin
      // Accept and retire together only happen with sel == tgt, so the
      // tgt write is harmless there.
      if (m_addr_ok) tgt <= sel;
      case ({m_addr_ok, m_data_ok})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
      if (unexp) err <= 1'b1;
    end
  end

endmodule
